// File: rtl/riscvsys_memarb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscvsys_memarb_pkg
//  Description : Shared types and constants for the riscvsys memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscvsys_memarb_pkg;

    // Arbiter state: no grant held, or a grant locked to owner_q
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int N_REQ_DFLT = 2;
    localparam int AW_DFLT    = 32;
    localparam int DW_DFLT    = 32;

    // Testbench control addresses decoded downstream of the arbiter
    localparam logic [31:0] MMIO_PUTC = 32'h1000_0000;
    localparam logic [31:0] MMIO_CTRL = 32'h2000_0000;

endpackage
`default_nettype wire

// File: rtl/riscvsys_rrpick.sv
`default_nettype none
// ============================================================================
//  Module      : riscvsys_rrpick
//  Description : Combinational round-robin picker. Returns the first set
//                request index at or after prio_i, wrapping N-1 -> 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module riscvsys_rrpick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] prio_i,
    output logic          any_o,
    output logic [IW-1:0] idx_o
);

    localparam logic [IW:0] NV = (IW+1)'(N);

    logic [2*N-1:0] w_dbl;
    logic [2*N-1:0] w_shift;
    logic [N-1:0]   w_rot;
    logic [IW-1:0]  w_off;
    logic [IW:0]    w_sum;

    // Rotate requests so prio_i lands at bit 0, find the lowest set bit,
    // then rotate the offset back into an absolute index.
    always_comb begin
        w_dbl   = {req_i, req_i};
        w_shift = w_dbl >> prio_i;
        w_rot   = w_shift[N-1:0];
        w_off   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = IW'(k);
            end
        end
        w_sum = {1'b0, prio_i} + {1'b0, w_off};
        if (w_sum >= NV) begin
            w_sum = w_sum - NV;
        end
        any_o = |req_i;
        idx_o = w_sum[IW-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/riscvsys_memarb.sv
`default_nettype none
// ============================================================================
//  Module      : riscvsys_memarb
//  Description : Round-robin arbiter sharing one native valid/ready memory
//                port between N_REQ requesters, with per-requester
//                saturating grant counters and an abort pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module riscvsys_memarb
    import riscvsys_memarb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DFLT,
    parameter int AW    = AW_DFLT,
    parameter int DW    = DW_DFLT,
    parameter int CNT_W = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [N_REQ-1:0]       i_req_valid,
    input  logic [N_REQ-1:0]       i_req_instr,
    input  logic [N_REQ*AW-1:0]    i_req_addr,
    input  logic [N_REQ*DW-1:0]    i_req_wdata,
    input  logic [N_REQ*DW/8-1:0]  i_req_wstrb,
    output logic [N_REQ-1:0]       o_req_ready,
    output logic [DW-1:0]          o_req_rdata,
    output logic                   o_mem_valid,
    output logic                   o_mem_instr,
    output logic [AW-1:0]          o_mem_addr,
    output logic [DW-1:0]          o_mem_wdata,
    output logic [DW/8-1:0]        o_mem_wstrb,
    input  logic                   i_mem_ready,
    input  logic [DW-1:0]          i_mem_rdata,
    output logic [$clog2(N_REQ)-1:0] o_owner,
    output logic                   o_busy,
    output logic [N_REQ*CNT_W-1:0] o_grant_cnt,
    output logic                   o_abort
);

    localparam int            OW       = $clog2(N_REQ);
    localparam int            SW       = DW / 8;
    localparam logic [OW-1:0] LAST_IDX = OW'(N_REQ - 1);

    state_t         state_q, state_d;
    logic [OW-1:0]  owner_q, owner_d;
    logic [OW-1:0]  prio_q,  prio_d;

    logic [AW-1:0]  w_addr  [N_REQ];
    logic [DW-1:0]  w_wdata [N_REQ];
    logic [SW-1:0]  w_wstrb [N_REQ];

    logic           w_any;
    logic [OW-1:0]  w_pick;
    logic           w_grant;
    logic           w_own_valid;
    logic           w_done;
    logic           w_abort;

    // Split the flat request buses into per-requester fields
    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign w_addr[g]  = i_req_addr[g*AW +: AW];
        assign w_wdata[g] = i_req_wdata[g*DW +: DW];
        assign w_wstrb[g] = i_req_wstrb[g*SW +: SW];
    end

    riscvsys_rrpick #(
        .N  (N_REQ),
        .IW (OW)
    ) u_pick (
        .req_i  (i_req_valid),
        .prio_i (prio_q),
        .any_o  (w_any),
        .idx_o  (w_pick)
    );

    assign w_grant     = (state_q == GRANT);
    assign w_own_valid = i_req_valid[owner_q];
    assign w_done      = w_grant & w_own_valid & i_mem_ready;
    assign w_abort     = w_grant & ~w_own_valid;

    // State, owner and priority registers; reset drops any in-flight transfer
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            prio_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
        end
    end

    // Next-state logic plus the downstream mux and completion/abort outputs
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        prio_d      = prio_q;
        o_req_ready = '0;
        o_req_rdata = '0;
        o_mem_valid = 1'b0;
        o_mem_instr = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_wstrb = '0;
        o_abort     = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_any) begin
                    state_d = GRANT;
                    owner_d = w_pick;
                    // The winner drops to lowest priority for the next round
                    prio_d  = (w_pick == LAST_IDX) ? '0 : w_pick + 1'b1;
                end
            end
            GRANT: begin
                o_mem_valid = w_own_valid;
                o_mem_instr = i_req_instr[owner_q];
                o_mem_addr  = w_addr[owner_q];
                o_mem_wdata = w_wdata[owner_q];
                o_mem_wstrb = w_wstrb[owner_q];
                if (w_done) begin
                    o_req_ready[owner_q] = 1'b1;
                    o_req_rdata          = i_mem_rdata;
                    state_d              = IDLE;
                end else if (w_abort) begin
                    o_abort = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_owner = owner_q;
    assign o_busy  = w_grant;

    // Per-requester completion counters, saturating at all-ones
    for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q, cnt_d;

        // Count a completion that belongs to this requester
        always_comb begin
            cnt_d = cnt_q;
            if (w_done && (owner_q == OW'(g)) && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // Counter register, cleared by reset
        always_ff @(posedge i_clk) begin
            if (!i_rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign o_grant_cnt[g*CNT_W +: CNT_W] = cnt_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_riscvsys_memarb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_riscvsys_memarb
//  Description : Self-checking bench for riscvsys_memarb: directed scenarios
//                with literal expectations, then randomized traffic checked
//                every cycle against a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_riscvsys_memarb;

    localparam int NR    = 2;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int SW    = DW / 8;
    localparam int CNT_W = 4;
    localparam int CMAX  = 15;

    logic                 i_clk;
    logic                 i_rst;
    logic [NR-1:0]        req_valid;
    logic [NR-1:0]        req_instr;
    logic [NR*AW-1:0]     req_addr;
    logic [NR*DW-1:0]     req_wdata;
    logic [NR*SW-1:0]     req_wstrb;
    logic [NR-1:0]        o_req_ready;
    logic [DW-1:0]        o_req_rdata;
    logic                 o_mem_valid;
    logic                 o_mem_instr;
    logic [AW-1:0]        o_mem_addr;
    logic [DW-1:0]        o_mem_wdata;
    logic [SW-1:0]        o_mem_wstrb;
    logic                 i_mem_ready;
    logic [DW-1:0]        i_mem_rdata;
    logic [0:0]           o_owner;
    logic                 o_busy;
    logic [NR*CNT_W-1:0]  o_grant_cnt;
    logic                 o_abort;

    riscvsys_memarb #(
        .N_REQ (NR),
        .AW    (AW),
        .DW    (DW),
        .CNT_W (CNT_W)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req_valid (req_valid),
        .i_req_instr (req_instr),
        .i_req_addr  (req_addr),
        .i_req_wdata (req_wdata),
        .i_req_wstrb (req_wstrb),
        .o_req_ready (o_req_ready),
        .o_req_rdata (o_req_rdata),
        .o_mem_valid (o_mem_valid),
        .o_mem_instr (o_mem_instr),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_mem_wstrb (o_mem_wstrb),
        .i_mem_ready (i_mem_ready),
        .i_mem_rdata (i_mem_rdata),
        .o_owner     (o_owner),
        .o_busy      (o_busy),
        .o_grant_cnt (o_grant_cnt),
        .o_abort     (o_abort)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: who holds the port (-1 = nobody), who is favoured
    // next, and how many transfers each requester has completed.
    // ------------------------------------------------------------------
    int          m_holder = -1;
    int          m_last_owner = 0;
    int          m_favoured = 0;
    int          m_done_cnt [NR];
    bit          seen_reset = 0;
    logic [NR-1:0] exp_ready_last = '0;
    logic [NR-1:0] e_ready;
    bit          e_abort;
    int          winner;

    initial begin
        for (int r = 0; r < NR; r++) m_done_cnt[r] = 0;
    end

    // Compare DUT against the model mid-cycle, then advance the model
    initial begin
        forever begin
            @(negedge i_clk);
            e_ready = '0;
            e_abort = 1'b0;
            if (m_holder >= 0) begin
                if (req_valid[m_holder]) begin
                    if (i_mem_ready) e_ready[m_holder] = 1'b1;
                end else begin
                    e_abort = 1'b1;
                end
            end
            if (seen_reset) begin
                check("busy",  o_busy,  (m_holder >= 0));
                check("owner", o_owner, m_last_owner);
                if (m_holder >= 0) begin
                    check("mem_valid", o_mem_valid, req_valid[m_holder]);
                    check("mem_instr", o_mem_instr, req_instr[m_holder]);
                    check("mem_addr",  o_mem_addr,  req_addr[m_holder*AW +: AW]);
                    check("mem_wdata", o_mem_wdata, req_wdata[m_holder*DW +: DW]);
                    check("mem_wstrb", o_mem_wstrb, req_wstrb[m_holder*SW +: SW]);
                end else begin
                    check("mem_idle", {o_mem_valid, o_mem_instr, o_mem_addr, o_mem_wstrb}, '0);
                    check("mem_idle_wdata", o_mem_wdata, '0);
                end
                check("req_ready", o_req_ready, e_ready);
                check("abort", o_abort, e_abort);
                if (e_ready != '0) check("rdata", o_req_rdata, i_mem_rdata);
                for (int r = 0; r < NR; r++)
                    check("grant_cnt", o_grant_cnt[r*CNT_W +: CNT_W], m_done_cnt[r]);
            end
            exp_ready_last = e_ready;
            if (!i_rst) begin
                m_holder     = -1;
                m_last_owner = 0;
                m_favoured   = 0;
                for (int r = 0; r < NR; r++) m_done_cnt[r] = 0;
                seen_reset   = 1'b1;
            end else if (m_holder < 0) begin
                if (req_valid != '0) begin
                    winner = -1;
                    for (int k = 0; k < NR; k++) begin
                        if (winner < 0 && req_valid[(m_favoured + k) % NR]) winner = (m_favoured + k) % NR;
                    end
                    m_holder     = winner;
                    m_last_owner = winner;
                    m_favoured   = (winner + 1) % NR;
                end
            end else if (e_abort) begin
                m_holder = -1;
            end else if (e_ready != '0) begin
                if (m_done_cnt[m_holder] < CMAX) m_done_cnt[m_holder]++;
                m_holder = -1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic peek();
        #2;
    endtask

    task automatic do_reset();
        step();
        i_rst       = 1'b0;
        req_valid   = '0;
        i_mem_ready = 1'b0;
        step();
        step();
        i_rst = 1'b1;
    endtask

    task automatic new_req(input int r);
        req_valid[r]             = 1'b1;
        req_instr[r]             = 1'($urandom_range(0, 1));
        req_addr[r*AW +: AW]     = $urandom;
        req_wdata[r*DW +: DW]    = $urandom;
        req_wstrb[r*SW +: SW]    = ($urandom_range(0, 1) == 0) ? '0 : SW'($urandom);
    endtask

    task automatic random_cycle();
        step();
        for (int r = 0; r < NR; r++) begin
            if (req_valid[r]) begin
                if (exp_ready_last[r]) begin
                    if ($urandom_range(0, 1) == 1) new_req(r);
                    else req_valid[r] = 1'b0;
                end else if ($urandom_range(0, 29) == 0) begin
                    req_valid[r] = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                new_req(r);
            end
        end
        i_mem_ready = ($urandom_range(0, 2) != 0);
        i_mem_rdata = $urandom;
        i_rst       = ($urandom_range(0, 299) != 0);
    endtask

    int n_done;
    int pulses;

    initial begin
        i_rst       = 1'b0;
        req_valid   = '0;
        req_instr   = '0;
        req_addr    = '0;
        req_wdata   = '0;
        req_wstrb   = '0;
        i_mem_ready = 1'b0;
        i_mem_rdata = '0;

        // Reset state
        repeat (3) step();
        i_rst = 1'b1;
        peek();
        check("rst_busy",  o_busy, 0);
        check("rst_mem",   {o_mem_valid, o_mem_addr, o_mem_wdata}, '0);
        check("rst_ready", {o_req_ready, o_abort, o_owner}, '0);
        check("rst_cnt",   o_grant_cnt, '0);
        check("rst_rdata", o_req_rdata, '0);

        // Single read, zero-wait memory
        step();
        req_valid        = 2'b01;
        req_addr[31:0]   = 32'h0000_0100;
        req_wstrb[3:0]   = 4'b0000;
        i_mem_ready      = 1'b1;
        i_mem_rdata      = 32'hDEAD_BEEF;
        peek();
        check("rd_idle_valid", o_mem_valid, 0);
        step();
        peek();
        check("rd_mem_valid", o_mem_valid, 1);
        check("rd_mem_addr",  o_mem_addr, 32'h100);
        check("rd_ready",     o_req_ready, 2'b01);
        check("rd_rdata",     o_req_rdata, 32'hDEAD_BEEF);
        step();
        req_valid = '0;
        peek();
        check("rd_cnt0", o_grant_cnt[3:0], 1);

        // Both requesters continuously valid: grants alternate 0,1,0,1
        do_reset();
        req_valid   = 2'b11;
        i_mem_ready = 1'b1;
        n_done      = 0;
        for (int c = 0; c < 16; c++) begin
            peek();
            if (o_req_ready != '0) begin
                check("alt_order", o_req_ready, ((n_done % 2) == 0) ? 2'b01 : 2'b10);
                n_done++;
            end
            step();
        end
        req_valid = '0;
        peek();
        check("alt_n_done", n_done, 8);
        check("alt_cnt0", o_grant_cnt[3:0], 4);
        check("alt_cnt1", o_grant_cnt[7:4], 4);

        // Requester 1 write with three memory wait cycles
        do_reset();
        req_valid         = 2'b10;
        req_addr[63:32]   = 32'h0000_0200;
        req_wdata[63:32]  = 32'h1234_5678;
        req_wstrb[7:4]    = 4'b0011;
        i_mem_ready       = 1'b0;
        pulses            = 0;
        step();
        for (int c = 0; c < 4; c++) begin
            if (c == 3) i_mem_ready = 1'b1;
            peek();
            check("wr_valid", o_mem_valid, 1);
            check("wr_addr",  o_mem_addr, 32'h200);
            check("wr_wdata", o_mem_wdata, 32'h1234_5678);
            check("wr_wstrb", o_mem_wstrb, 4'b0011);
            if (o_req_ready == 2'b10) pulses++;
            step();
        end
        req_valid   = '0;
        i_mem_ready = 1'b0;
        peek();
        if (o_req_ready != '0) pulses++;
        check("wr_pulses", pulses, 1);
        check("wr_cnt1",   o_grant_cnt[7:4], 1);

        // Owner withdraws after one wait cycle
        do_reset();
        req_valid       = 2'b01;
        req_addr[31:0]  = 32'h0000_0300;
        req_wstrb       = '0;
        i_mem_ready     = 1'b0;
        step();
        peek();
        check("ab_busy",  o_busy, 1);
        check("ab_owner", o_owner, 0);
        step();
        req_valid        = 2'b10;
        req_addr[63:32]  = 32'h0000_0400;
        peek();
        check("ab_abort", o_abort, 1);
        check("ab_ready", o_req_ready, 0);
        step();
        req_valid = 2'b11;
        peek();
        check("ab_abort_off", o_abort, 0);
        check("ab_idle",      o_busy, 0);
        step();
        peek();
        check("ab_next_owner", o_owner, 1);
        check("ab_next_addr",  o_mem_addr, 32'h400);
        check("ab_cnt0",       o_grant_cnt[3:0], 0);
        step();
        req_valid = '0;

        // Reset during a stalled transfer
        do_reset();
        req_valid   = 2'b10;
        i_mem_ready = 1'b1;
        step();
        step();
        req_valid   = 2'b01;
        i_mem_ready = 1'b0;
        step();
        step();
        i_rst = 1'b0;
        peek();
        check("mr_busy_pre", o_busy, 1);
        check("mr_cnt1_pre", o_grant_cnt[7:4], 1);
        step();
        req_valid = 2'b11;
        peek();
        check("mr_busy",  o_busy, 0);
        check("mr_mem",   {o_mem_valid, o_mem_addr, o_mem_wdata, o_mem_wstrb}, '0);
        check("mr_ready", {o_req_ready, o_abort, o_owner}, '0);
        check("mr_cnt",   o_grant_cnt, '0);
        step();
        i_rst = 1'b1;
        step();
        peek();
        check("mr_first_owner", o_owner, 0);
        check("mr_first_busy",  o_busy, 1);
        step();
        req_valid = '0;

        // Counter saturation
        do_reset();
        req_valid      = 2'b01;
        req_addr[31:0] = 32'h0000_0500;
        i_mem_ready    = 1'b1;
        repeat (30) step();
        peek();
        check("sat_15", o_grant_cnt[3:0], 4'hF);
        repeat (10) step();
        req_valid = '0;
        peek();
        check("sat_hold", o_grant_cnt[3:0], 4'hF);

        // Randomized traffic against the model
        do_reset();
        repeat (4000) random_cycle();
        step();
        req_valid   = '0;
        i_mem_ready = 1'b0;
        i_rst       = 1'b1;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
